// File: rtl/hall_decoder.sv
// Hall-sensor commutation decoder: synchronizes and debounces {HA,HB,HC}, tracks the
// sector, counts signed steps, measures step period and flags stall and sensor faults.
module hall_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STALL_CYCLES    = 16777215
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  hall_i,
  input  logic        fault_clr_i,
  output logic [2:0]  sector_o,
  output logic        sector_valid_o,
  output logic        dir_o,
  output logic        step_o,
  output logic [15:0] position_o,
  output logic [23:0] period_o,
  output logic        period_valid_o,
  output logic        stall_o,
  output logic        fault_o
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [23:0]   STALL_LIM = 24'(STALL_CYCLES);
  localparam logic [23:0]   TIMER_MAX = 24'hFF_FFFF;

  typedef enum logic {NOSYNC = 1'b0, TRACK = 1'b1} state_e;

  // {legal, sector}; 000 and 111 decode as illegal
  function automatic logic [3:0] decode(input logic [2:0] code);
    case (code)
      3'b101:  decode = {1'b1, 3'd0};
      3'b100:  decode = {1'b1, 3'd1};
      3'b110:  decode = {1'b1, 3'd2};
      3'b010:  decode = {1'b1, 3'd3};
      3'b011:  decode = {1'b1, 3'd4};
      3'b001:  decode = {1'b1, 3'd5};
      default: decode = {1'b0, 3'd0};
    endcase
  endfunction

  logic [1:0]    rst_pipe_q;
  logic          rst_core_n;
  logic [2:0]    sync1_q, sync2_q, cand_q, acc_code_q;
  logic          acc_valid_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q;
  logic [2:0]    sector_q;
  logic          sector_valid_q, dir_q, step_q, period_valid_q, stall_q, fault_q;
  logic [15:0]   position_q;
  logic [23:0]   period_q, timer_q;
  logic          seen_q, armed_q;
  logic [3:0]    dec_s;
  logic [2:0]    sec_next_s, sec_prev_s;
  logic          accept_s, fwd_s, rev_s, stall_now_s;

  // Reset is asserted asynchronously but released only on a clock edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_pipe_q <= 2'b00;
    end else begin
      rst_pipe_q <= {rst_pipe_q[0], 1'b1};
    end
  end

  assign rst_core_n = rst_pipe_q[1];

  // Two-flop synchronizer followed by the debounce candidate register
  always_ff @(posedge clk_i or negedge rst_core_n) begin
    if (!rst_core_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      cand_q  <= 3'b000;
      cnt_q   <= '0;
    end else begin
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  // Stability counter: restarts on any change, parks at DEBOUNCE_CYCLES so acceptance fires once
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q != cand_q) begin
      cnt_d = '0;
    end else if (cnt_q != DEB_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign accept_s    = (sync2_q == cand_q) && (cnt_q == DEB_LAST) &&
                       (!acc_valid_q || (sync2_q != acc_code_q));
  assign dec_s       = decode(sync2_q);
  assign sec_next_s  = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
  assign sec_prev_s  = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
  assign fwd_s       = (dec_s[2:0] == sec_next_s);
  assign rev_s       = (dec_s[2:0] == sec_prev_s);
  assign stall_now_s = (timer_q >= STALL_LIM);

  // Decoder FSM with step timer, period measurement, stall and sticky fault
  always_ff @(posedge clk_i or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q        <= NOSYNC;
      sector_q       <= 3'd0;
      sector_valid_q <= 1'b0;
      dir_q          <= 1'b1;
      step_q         <= 1'b0;
      position_q     <= 16'd0;
      period_q       <= 24'd0;
      period_valid_q <= 1'b0;
      stall_q        <= 1'b0;
      fault_q        <= 1'b0;
      timer_q        <= 24'd0;
      acc_code_q     <= 3'b000;
      acc_valid_q    <= 1'b0;
      seen_q         <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (timer_q != TIMER_MAX) begin
        timer_q <= timer_q + 24'd1;
      end
      if (fault_clr_i) begin
        fault_q <= 1'b0;
      end
      if (stall_now_s) begin
        stall_q        <= 1'b1;
        period_valid_q <= 1'b0;
        armed_q        <= 1'b0;
      end
      if (accept_s) begin
        acc_code_q  <= sync2_q;
        acc_valid_q <= 1'b1;
        if (!dec_s[3]) begin
          fault_q        <= 1'b1;
          sector_valid_q <= 1'b0;
          period_valid_q <= 1'b0;
          seen_q         <= 1'b0;
          armed_q        <= 1'b0;
          state_q        <= NOSYNC;
        end else begin
          case (state_q)
            NOSYNC: begin
              sector_q       <= dec_s[2:0];
              sector_valid_q <= 1'b1;
              period_valid_q <= 1'b0;
              timer_q        <= 24'd0;
              seen_q         <= 1'b0;
              armed_q        <= 1'b0;
              state_q        <= TRACK;
            end
            TRACK: begin
              sector_q <= dec_s[2:0];
              if (fwd_s || rev_s) begin
                step_q     <= 1'b1;
                dir_q      <= fwd_s;
                position_q <= fwd_s ? position_q + 16'd1 : position_q - 16'd1;
                timer_q    <= 24'd0;
                stall_q    <= 1'b0;
                seen_q     <= 1'b1;
                // armed only after a step that itself followed a step
                armed_q    <= seen_q;
                if (armed_q && !stall_q && !stall_now_s && (fwd_s == dir_q)) begin
                  period_q       <= timer_q + 24'd1;
                  period_valid_q <= 1'b1;
                end else begin
                  period_valid_q <= 1'b0;
                end
              end else begin
                fault_q        <= 1'b1;
                period_valid_q <= 1'b0;
                seen_q         <= 1'b0;
                armed_q        <= 1'b0;
              end
            end
            default: state_q <= NOSYNC;
          endcase
        end
      end
    end
  end

  assign sector_o       = sector_q;
  assign sector_valid_o = sector_valid_q;
  assign dir_o          = dir_q;
  assign step_o         = step_q;
  assign position_o     = position_q;
  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign stall_o        = stall_q;
  assign fault_o        = fault_q;

endmodule

// File: tb/tb_hall_decoder.sv
// Directed bench for hall_decoder: default instance, short-stall instance and a
// fast-debounce instance used to reach the position wrap points.
module tb_hall_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  hall_a, hall_s, hall_w;
  logic        clr_a, clr_s, clr_w;
  logic [2:0]  sec_a, sec_s, sec_w;
  logic        sv_a, sv_s, sv_w, dir_a, dir_s, dir_w, step_a, step_s, step_w;
  logic [15:0] pos_a, pos_s, pos_w;
  logic [23:0] per_a, per_s, per_w;
  logic        pv_a, pv_s, pv_w, stall_a, stall_s, stall_w, fault_a, fault_s, fault_w;

  int checks = 0;
  int errors = 0;
  int nstep_a = 0;
  int nstep_s = 0;
  logic [2:0] codes [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  hall_decoder dut (
    .clk_i(clk), .rst_ni(rst_n), .hall_i(hall_a), .fault_clr_i(clr_a),
    .sector_o(sec_a), .sector_valid_o(sv_a), .dir_o(dir_a), .step_o(step_a),
    .position_o(pos_a), .period_o(per_a), .period_valid_o(pv_a),
    .stall_o(stall_a), .fault_o(fault_a)
  );

  hall_decoder #(.DEBOUNCE_CYCLES(16), .STALL_CYCLES(100)) dut_st (
    .clk_i(clk), .rst_ni(rst_n), .hall_i(hall_s), .fault_clr_i(clr_s),
    .sector_o(sec_s), .sector_valid_o(sv_s), .dir_o(dir_s), .step_o(step_s),
    .position_o(pos_s), .period_o(per_s), .period_valid_o(pv_s),
    .stall_o(stall_s), .fault_o(fault_s)
  );

  hall_decoder #(.DEBOUNCE_CYCLES(1)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .hall_i(hall_w), .fault_clr_i(clr_w),
    .sector_o(sec_w), .sector_valid_o(sv_w), .dir_o(dir_w), .step_o(step_w),
    .position_o(pos_w), .period_o(per_w), .period_valid_o(pv_w),
    .stall_o(stall_w), .fault_o(fault_w)
  );

  always @(negedge clk) begin
    if (step_a) nstep_a <= nstep_a + 1;
    if (step_s) nstep_s <= nstep_s + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    hall_a = 3'b101; hall_s = 3'b101; hall_w = 3'b101;
    clr_a = 1'b0; clr_s = 1'b0; clr_w = 1'b0;
    wait_cyc(3);
    chk("rst_sector",   32'(sec_a),   32'd0);
    chk("rst_valid",    32'(sv_a),    32'd0);
    chk("rst_dir",      32'(dir_a),   32'd1);
    chk("rst_step",     32'(step_a),  32'd0);
    chk("rst_position", 32'(pos_a),   32'd0);
    chk("rst_period",   32'(per_a),   32'd0);
    chk("rst_pvalid",   32'(pv_a),    32'd0);
    chk("rst_stall",    32'(stall_a), 32'd0);
    chk("rst_fault",    32'(fault_a), 32'd0);

    rst_n = 1'b1;
    wait_cyc(30);
    chk("sync_valid",    32'(sv_a),    32'd1);
    chk("sync_sector",   32'(sec_a),   32'd0);
    chk("sync_nostep",   32'(nstep_a), 32'd0);
    chk("sync_position", 32'(pos_a),   32'd0);
    chk("st_sync_valid", 32'(sv_s),    32'd1);
    chk("st_no_stall",   32'(stall_s), 32'd0);
    chk("w_sync_valid",  32'(sv_w),    32'd1);

    // stall instance: 100 idle cycles after sync, then one adjacent step
    wait_cyc(120);
    chk("stall_set",    32'(stall_s), 32'd1);
    chk("stall_pvalid", 32'(pv_s),    32'd0);
    hall_s = 3'b100;
    wait_cyc(30);
    chk("stall_clear",      32'(stall_s), 32'd0);
    chk("stall_step",       32'(nstep_s), 32'd1);
    chk("stall_step_pv",    32'(pv_s),    32'd0);
    chk("stall_step_pos",   32'(pos_s),   32'd1);

    // forward revolution, 1000 cycles per code
    for (int k = 1; k <= 6; k++) begin
      hall_a = codes[k % 6];
      wait_cyc(1000);
      chk("fwd_position", 32'(pos_a), 32'(k));
      chk("fwd_dir",      32'(dir_a), 32'd1);
      chk("fwd_pvalid",   32'(pv_a),  32'(k >= 3));
      if (k >= 3) chk("fwd_period", 32'(per_a), 32'd1000);
    end
    chk("fwd_steps",  32'(nstep_a), 32'd6);
    chk("fwd_sector", 32'(sec_a),   32'd0);

    // short glitch is rejected
    hall_a = 3'b100;
    wait_cyc(10);
    hall_a = 3'b101;
    wait_cyc(40);
    chk("glitch_steps",  32'(nstep_a), 32'd6);
    chk("glitch_sector", 32'(sec_a),   32'd0);

    // skip from sector 0 to 3, then illegal code, then clear
    hall_a = 3'b010;
    wait_cyc(40);
    chk("skip_fault",    32'(fault_a), 32'd1);
    chk("skip_sector",   32'(sec_a),   32'd3);
    chk("skip_position", 32'(pos_a),   32'd6);
    chk("skip_valid",    32'(sv_a),    32'd1);
    chk("skip_steps",    32'(nstep_a), 32'd6);
    chk("skip_pvalid",   32'(pv_a),    32'd0);
    hall_a = 3'b111;
    wait_cyc(40);
    chk("illegal_valid",  32'(sv_a),    32'd0);
    chk("illegal_sector", 32'(sec_a),   32'd3);
    chk("illegal_fault",  32'(fault_a), 32'd1);
    clr_a = 1'b1;
    wait_cyc(1);
    clr_a = 1'b0;
    wait_cyc(2);
    chk("fault_clear", 32'(fault_a), 32'd0);

    // wrap instance: 32767 forward steps, two cycles apiece
    for (int i = 1; i <= 32767; i++) begin
      hall_w = codes[i % 6];
      wait_cyc(2);
    end
    wait_cyc(6);
    chk("wrap_max",     32'(pos_w), 32'h7FFF);
    chk("wrap_pvalid",  32'(pv_w),  32'd1);
    chk("wrap_period",  32'(per_w), 32'd2);
    hall_w = codes[2];
    wait_cyc(6);
    chk("wrap_min",     32'(pos_w), 32'h8000);
    chk("wrap_min_dir", 32'(dir_w), 32'd1);
    hall_w = codes[1];
    wait_cyc(6);
    chk("wrap_back",     32'(pos_w), 32'h7FFF);
    chk("wrap_back_dir", 32'(dir_w), 32'd0);
    chk("wrap_back_pv",  32'(pv_w),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hall_decoder.md
HALL_DECODER -- requirements
Module: hall_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronized samples needed to accept a hall code.
REQ-002 Parameter STALL_CYCLES, default 16777215, is the number of cycles without a step before stall is declared (~1.05 s at 16 MHz).
REQ-003 CLK  in  1  16 MHz system clock; all logic is on its rising edge.
REQ-004 RST_N  in  1  Reset, asynchronous, active-low.
REQ-005 HALL  in  3  Raw hall inputs {HA,HB,HC}, asynchronous to CLK.
REQ-006 FAULT_CLR  in  1  Synchronous clear of FAULT.
REQ-007 SECTOR  out  3  Decoded sector 0..5.
REQ-008 SECTOR_VALID  out  1  SECTOR holds a legal decoded code.
REQ-009 DIR  out  1  Direction of the last step: 1 = forward, 0 = reverse.
REQ-010 STEP  out  1  One-cycle pulse per accepted adjacent sector transition.
REQ-011 POSITION  out  16  Signed step count, two's complement.
REQ-012 PERIOD  out  24  Cycles between the last two same-direction steps.
REQ-013 PERIOD_VALID  out  1  PERIOD is a current measurement.
REQ-014 STALL  out  1  No step for STALL_CYCLES cycles.
REQ-015 FAULT  out  1  Sticky error: illegal code or skipped sector.

Function
REQ-016 HALL is synchronized through two flops before any use.
- Hall inputs pass through two flops before use.
- Debounce: a counter clears on any change of the synchronized value.
- A code is accepted only when the value has stayed stable for DEBOUNCE_CYCLES cycles and differs from the last accepted code.
REQ-017 Sector map for HALL = HA,HB,HC: 101=0, 100=1, 110=2, 010=3, 011=4, 001=5; forward means (sector+1) mod 6; codes 000 and 111 are illegal.
REQ-018 Decoder FSM states are NOSYNC and TRACK; reset enters NOSYNC.
REQ-019 NOSYNC, legal code accepted:
- SECTOR = decoded value, SECTOR_VALID = 1, go to TRACK.
- No STEP pulse, no POSITION change; the step timer clears to 0.
REQ-020 TRACK, forward-adjacent code accepted:
- STEP = 1, DIR = 1, POSITION +1, SECTOR updated, all in the cycle after acceptance.
- Reverse-adjacent is the same with DIR = 0 and POSITION -1.
REQ-021 TRACK, legal non-adjacent code (skip of 2 or 3 sectors):
- FAULT = 1, SECTOR updated, no STEP, POSITION and DIR unchanged, PERIOD_VALID = 0.
REQ-022 Any state, illegal code accepted:
- FAULT = 1, SECTOR_VALID = 0, SECTOR held, PERIOD_VALID = 0, go to NOSYNC.
REQ-023 POSITION wraps: 32767 + 1 = -32768 and -32768 - 1 = 32767, with no flag.
REQ-024 Step timer behaviour:
- Increments every cycle and saturates at 2^24-1.
- On STEP, if the previous step had the same DIR, no stall or fault intervened, and this is not the first step after NOSYNC: PERIOD = timer+1 and PERIOD_VALID = 1.
- The timer then clears to 0.
REQ-025 On a STEP with DIR differing from the previous step, PERIOD_VALID = 0, PERIOD holds, and the timer restarts.
REQ-026 Stall:
- When the timer reaches STALL_CYCLES, STALL = 1 and PERIOD_VALID = 0.
- The next STEP clears STALL and restarts measurement; that step yields no PERIOD.
REQ-027 FAULT stays set until FAULT_CLR is high; if FAULT_CLR and a new fault occur in the same cycle, FAULT stays 1.

Reset
REQ-028 While RST_N = 0 (asynchronous assertion):
- SECTOR = 0, SECTOR_VALID = 0, DIR = 1, STEP = 0, POSITION = 0, PERIOD = 0, PERIOD_VALID = 0, STALL = 0, FAULT = 0.
- FSM in NOSYNC; synchronizer, debounce counter and timer cleared.
REQ-029 Deassertion of RST_N is synchronized to CLK, and reset asserted mid-step discards any pending accepted code.

Verification
REQ-030 Reset release, HALL = 101 held 20 cycles -> SECTOR_VALID = 1, SECTOR = 0, no STEP, POSITION = 0.
REQ-031 Forward sequence 101,100,110,010,011,001,101, each held 1000 cycles -> 6 STEP pulses, DIR = 1, POSITION = 6, PERIOD = 1000, PERIOD_VALID = 1 from the 3rd step on.
REQ-032 Glitch: HALL toggles 101->100->101 with a 10-cycle pulse -> no STEP, SECTOR stays 0.
REQ-033 From sector 0, apply 010 (skip to sector 3) -> FAULT = 1, SECTOR = 3, POSITION unchanged; then 111 -> SECTOR_VALID = 0; FAULT_CLR pulse -> FAULT = 0.
REQ-034 With STALL_CYCLES = 100 and no hall change for 100 cycles -> STALL = 1, PERIOD_VALID = 0; next adjacent code -> STALL = 0, STEP = 1, PERIOD_VALID still 0.
REQ-035 Preload POSITION = 32767 via forward steps and apply one more forward step -> POSITION = -32768; a reverse step then gives 32767 and PERIOD_VALID = 0.
